// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// FSM state encoding, load result-source code, perf event strobes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_e;

    localparam logic [2:0] RES_SRC_LOAD = 3'b001;

    // One strobe per counted event, sampled every cycle by the counter bank.
    typedef struct packed {
        logic stall;
        logic flush;
        logic lu;
    } perf_t;

endpackage

// File: rtl/pipe_perf_counters.sv
// Purpose: wrapping event counters for stall cycles, redirect flushes, load-use bubbles.
// Latency: counters reflect events up to the previous rising edge.
// Backpressure: none; one increment per strobe per cycle. Built only with PIPE_CTRL_PERF_EN.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_counters
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  perf_t            evt,
    output logic [CNT_W-1:0] stall_cyc,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (evt.stall) stall_cyc <= stall_cyc + ONE;
            if (evt.flush) flush_cnt <= flush_cnt + ONE;
            if (evt.lu)    lu_cnt    <= lu_cnt + ONE;
        end
    end

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Purpose: stall/flush sequencer for load-use, E-stage redirects and data-memory waits (PIPE_CTRL_PERF_EN adds counters).
// Latency: controls are combinational from registered state and current inputs (zero cycles).
// Backpressure: a data-memory wait freezes every stage; a wait past MEM_TIMEOUT locks into ERR until reset.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             reg_write_e,
    input  logic [2:0]       result_src_e,
    input  logic             redirect_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             bus_err,
    output logic [1:0]       state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_lu_cnt
`endif
);

    localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

    ctrl_state_e state;
    logic [7:0]  wait_cnt;
    logic [8:0]  wait_next;
    logic        bus_err_q;
    logic        lu;
    logic        mw;

    assign lu = reg_write_e && (result_src_e == RES_SRC_LOAD) && (rd_e != 5'd0)
                && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mw = dmem_req_m && !dmem_ready;

    // Counter counts wait cycles seen so far including the current one.
    assign wait_next = {1'b0, wait_cnt} + 9'd1;

    // MEM_WAIT shares the RUN decode: once mw drops, redirect/lu resolve in the same cycle.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst_n) begin
            stall_f = 1'b0;
        end else if (state == ERR || mw) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (redirect_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        wait_cnt <= 8'd1;
                        if (TIMEOUT <= 9'd1) begin
                            state     <= ERR;
                            bus_err_q <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mw) begin
                        wait_cnt <= wait_next[7:0];
                        if (wait_next >= TIMEOUT) begin
                            state     <= ERR;
                            bus_err_q <= 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign bus_err = bus_err_q;
    assign state_o = state;

`ifdef PIPE_CTRL_PERF_EN
    perf_t perf_evt;

    // A load-use bubble is the only case with stall_f and flush_e together.
    assign perf_evt.stall = stall_f && (state != ERR);
    assign perf_evt.flush = flush_d;
    assign perf_evt.lu    = stall_f && flush_e;

    pipe_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt       (perf_evt),
        .stall_cyc (perf_stall_cyc),
        .flush_cnt (perf_flush_cnt),
        .lu_cnt    (perf_lu_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and random stimulus for pipeline_ctrl, checked every cycle against a
// cycle-counting reference model of the hazard rules.
module tb_pipeline_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
    logic       reg_write_e = 1'b0;
    logic [2:0] result_src_e = '0;
    logic       redirect_e = 1'b0, dmem_req_m = 1'b0, dmem_ready = 1'b1;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, bus_err;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: consecutive wait cycles, error latch, event tallies.
    int         m_waits = 0;
    bit         m_err = 1'b0;
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_lu = '0;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e), .redirect_e(redirect_e),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .bus_err(bus_err),
        .state_o(state_o)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
        .perf_lu_cnt(perf_lu_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic [2:0] rsrc,
                       input logic redir, input logic req, input logic rdy);
        logic [9:0] obs, exp;
        logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_be;
        logic [1:0] e_st;
        bit lu_c, mw_c;
        rs1_d = rs1; rs2_d = rs2; rd_e = rd; reg_write_e = rw; result_src_e = rsrc;
        redirect_e = redir; dmem_req_m = req; dmem_ready = rdy;
        #4;
        lu_c = rw && (rsrc == 3'b001) && (rd != 0) && (rd == rs1 || rd == rs2);
        mw_c = req && !rdy;
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_be} = '0;
        e_st = 2'd0;
        if (!rst_n) begin
            m_waits = 0; m_err = 0; m_stall = '0; m_flush = '0; m_lu = '0;
        end else if (m_err) begin
            {e_sf, e_sd, e_se, e_sm, e_fw, e_be} = 6'b111111;
            e_st = 2'd2;
        end else begin
            e_st = (m_waits > 0) ? 2'd1 : 2'd0;
            if (mw_c)       {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
            else if (redir) {e_fd, e_fe} = 2'b11;
            else if (lu_c)  {e_sf, e_sd, e_fe} = 3'b111;
        end
        exp = {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_be, e_st};
        obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, bus_err, state_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (sf sd se sm fd fe fw be st)", tag, obs, exp);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        assert ({perf_stall_cyc, perf_flush_cnt, perf_lu_cnt} === {m_stall, m_flush, m_lu}) else begin
            errors++;
            $error("FAIL %s_perf: observed %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                   perf_stall_cyc, perf_flush_cnt, perf_lu_cnt, m_stall, m_flush, m_lu);
        end
`endif
        if (rst_n) begin
            if (e_sf && !m_err) m_stall = m_stall + 1'b1;
            if (e_fd)           m_flush = m_flush + 1'b1;
            if (e_sf && e_fe)   m_lu = m_lu + 1'b1;
            if (!m_err) begin
                if (mw_c) begin
                    m_waits++;
                    if (m_waits >= TO) m_err = 1'b1;
                end else begin
                    m_waits = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset: outputs forced low even with every hazard input active.
        cyc("rst_active", 5'd5, 5'd5, 5'd5, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
        cyc("rst_active2", 5'd5, 5'd5, 5'd5, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        idle("idle0");

        // Load-use on rs1: a single bubble.
        cyc("t1_lu", 5'd5, 5'd0, 5'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        cyc("t1_after", 5'd6, 5'd7, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Three-cycle memory freeze then ready.
        for (int i = 0; i < 3; i++) cyc("t3_wait", 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        cyc("t3_ready", 5'd1, 5'd2, 5'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1);
        idle("t3_idle");

        // Redirect with a load-use match, held through a two-cycle freeze.
        for (int i = 0; i < 2; i++) cyc("t4_freeze", 5'd5, 5'd0, 5'd5, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
        cyc("t4_unfreeze", 5'd5, 5'd0, 5'd5, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1);
        idle("t4_after");
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        assert (perf_stall_cyc === 32'd6 && perf_flush_cnt === 32'd1 && perf_lu_cnt === 32'd1) else begin
            errors++;
            $error("FAIL t6_perf: observed %0d/%0d/%0d expected 6/1/1",
                   perf_stall_cyc, perf_flush_cnt, perf_lu_cnt);
        end
`endif

        // rd_e = 0 never stalls; rs2 match stalls.
        cyc("t2_rd0", 5'd0, 5'd0, 5'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        cyc("t2_rs2", 5'd9, 5'd5, 5'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        cyc("t2_nonload", 5'd9, 5'd5, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);

        // Ready on the cycle that would hit the timeout: no error.
        for (int i = 0; i < TO - 1; i++) cyc("t5_near", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cyc("t5_ready_edge", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        // Abort without ready returns to RUN.
        cyc("t5_abort_w", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cyc("t5_abort", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        idle("t5_idle");

        // Timeout into ERR; ready ignored; reset recovers.
        for (int i = 0; i < TO; i++) cyc("t5_wait", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cyc("t5_err", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc("t5_err_hold", 5'd5, 5'd0, 5'd5, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc("t5_rst", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        idle("t5_post_rst");

        // Reset in the middle of a freeze.
        for (int i = 0; i < 2; i++) cyc("mw_rst_w", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc("mw_rst", 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        idle("mw_post_rst");

        // Random traffic over a small register space to make matches frequent.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] rsrc;
            rsrc = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            rst_n = !(m_err && $urandom_range(0, 3) == 0);
            cyc("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), rsrc, ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) > 5));
            rst_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
